// File: rtl/csr_file.sv
// csr_file: control/status register file with exception entry/return, a one-shot or
// periodic countdown timer feeding ESTAT.IS[11], and a free-running 64-bit stable counter.
module csr_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        exception_submit,
    input  logic [5:0]  ecode_submit,
    input  logic [8:0]  esubcode_submit,
    input  logic [31:0] exception_pc_submit,
    input  logic [31:0] exception_maddr_submit,
    input  logic        ertn_submit,
    input  logic [13:0] csr_num,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    output logic [31:0] csr_rvalue,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int,
    output logic [63:0] counter_value
);
    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    logic [1:0]  r_crmd_plv;
    logic        r_crmd_ie;
    logic        r_crmd_da;
    logic [1:0]  r_prmd_pplv;
    logic        r_prmd_pie;
    logic [12:0] r_ecfg_lie;
    logic [1:0]  r_estat_is_sw;
    logic        r_estat_is_timer;
    logic [5:0]  r_estat_ecode;
    logic [8:0]  r_estat_esubcode;
    logic [31:0] r_era;
    logic [31:0] r_badv;
    logic [25:0] r_eentry;
    logic [31:0] r_save [4];
    logic [31:0] r_tid;
    logic        r_tcfg_en;
    logic        r_tcfg_periodic;
    logic [29:0] r_tcfg_initval;
    logic [31:0] r_tval;
    logic [63:0] r_counter;

    logic [12:0] w_is;
    logic [31:0] w_merged;
    logic        w_wr;
    logic        w_tcfg_wr;
    logic        w_ticlr;
    logic        w_expire;

    function automatic logic [31:0] masked_merge(input logic [31:0] old_val,
                                                 input logic [31:0] mask,
                                                 input logic [31:0] value);
        return (old_val & ~mask) | (value & mask);
    endfunction

    assign w_is = {1'b0, r_estat_is_timer, 9'h000, r_estat_is_sw};

    always_comb begin
        csr_rvalue = 32'h0;
        case (csr_num)
            CSR_CRMD:   csr_rvalue = {28'h0, r_crmd_da, r_crmd_ie, r_crmd_plv};
            CSR_PRMD:   csr_rvalue = {29'h0, r_prmd_pie, r_prmd_pplv};
            CSR_ECFG:   csr_rvalue = {19'h0, r_ecfg_lie};
            CSR_ESTAT:  csr_rvalue = {1'b0, r_estat_esubcode, r_estat_ecode, 3'b000, w_is};
            CSR_ERA:    csr_rvalue = r_era;
            CSR_BADV:   csr_rvalue = r_badv;
            CSR_EENTRY: csr_rvalue = {r_eentry, 6'h00};
            CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                        csr_rvalue = r_save[csr_num[1:0]];
            CSR_TID:    csr_rvalue = r_tid;
            CSR_TCFG:   csr_rvalue = {r_tcfg_initval, r_tcfg_periodic, r_tcfg_en};
            CSR_TVAL:   csr_rvalue = r_tval;
            default:    csr_rvalue = 32'h0;
        endcase
    end

    // Read-only and unimplemented bits read 0, so merging onto the read value is safe.
    assign w_merged  = masked_merge(csr_rvalue, csr_wmask, csr_wvalue);
    assign w_wr      = csr_we & ~exception_submit & ~ertn_submit;
    assign w_tcfg_wr = w_wr & (csr_num == CSR_TCFG);
    assign w_ticlr   = w_wr & (csr_num == CSR_TICLR) & csr_wmask[0] & csr_wvalue[0];
    assign w_expire  = r_tcfg_en & (r_tval == 32'd1);

    assign ex_entry      = {r_eentry, 6'h00};
    assign ertn_entry    = r_era;
    assign has_int       = r_crmd_ie & (|(w_is & r_ecfg_lie));
    assign counter_value = r_counter;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crmd_plv       <= 2'b00;
            r_crmd_ie        <= 1'b0;
            r_crmd_da        <= 1'b1;
            r_prmd_pplv      <= 2'b00;
            r_prmd_pie       <= 1'b0;
            r_ecfg_lie       <= 13'h0;
            r_estat_is_sw    <= 2'b00;
            r_estat_ecode    <= 6'h0;
            r_estat_esubcode <= 9'h0;
            r_era            <= 32'h0;
            r_badv           <= 32'h0;
            r_eentry         <= 26'h0;
            for (int i = 0; i < 4; i++) r_save[i] <= 32'h0;
            r_tid            <= 32'h0;
            r_tcfg_en        <= 1'b0;
            r_tcfg_periodic  <= 1'b0;
            r_tcfg_initval   <= 30'h0;
            r_counter        <= 64'h0;
        end else begin
            r_counter <= r_counter + 64'd1;
            if (exception_submit) begin
                r_prmd_pplv      <= r_crmd_plv;
                r_prmd_pie       <= r_crmd_ie;
                r_crmd_plv       <= 2'b00;
                r_crmd_ie        <= 1'b0;
                r_era            <= exception_pc_submit;
                r_estat_ecode    <= ecode_submit;
                r_estat_esubcode <= esubcode_submit;
                if (ecode_submit == ECODE_ADEF)
                    r_badv <= exception_pc_submit;
                else if (ecode_submit == ECODE_ALE)
                    r_badv <= exception_maddr_submit;
            end else if (ertn_submit) begin
                r_crmd_plv <= r_prmd_pplv;
                r_crmd_ie  <= r_prmd_pie;
            end else if (csr_we) begin
                case (csr_num)
                    CSR_CRMD: begin
                        r_crmd_plv <= w_merged[1:0];
                        r_crmd_ie  <= w_merged[2];
                        r_crmd_da  <= w_merged[3];
                    end
                    CSR_PRMD: begin
                        r_prmd_pplv <= w_merged[1:0];
                        r_prmd_pie  <= w_merged[2];
                    end
                    CSR_ECFG:   r_ecfg_lie    <= {w_merged[12:11], 1'b0, w_merged[9:0]};
                    CSR_ESTAT:  r_estat_is_sw <= w_merged[1:0];
                    CSR_ERA:    r_era         <= w_merged;
                    CSR_BADV:   r_badv        <= w_merged;
                    CSR_EENTRY: r_eentry      <= w_merged[31:6];
                    CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                                r_save[csr_num[1:0]] <= w_merged;
                    CSR_TID:    r_tid         <= w_merged;
                    CSR_TCFG: begin
                        r_tcfg_en       <= w_merged[0];
                        r_tcfg_periodic <= w_merged[1];
                        r_tcfg_initval  <= w_merged[31:2];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Timer: a TCFG write reloads the count; an expiry beats a same-edge TICLR clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tval           <= 32'h0;
            r_estat_is_timer <= 1'b0;
        end else begin
            if (w_tcfg_wr)
                r_tval <= {w_merged[31:2], 2'b00};
            else if (r_tcfg_en && (r_tval != 32'h0))
                r_tval <= w_expire ? (r_tcfg_periodic ? {r_tcfg_initval, 2'b00} : 32'h0)
                                   : (r_tval - 32'd1);
            if (w_expire)
                r_estat_is_timer <= 1'b1;
            else if (w_ticlr)
                r_estat_is_timer <= 1'b0;
        end
    end
endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 The block SHALL have these ports: clk in 1, single clock; all state updates on rising edge.
REQ-002 rst in 1, synchronous active-high reset.
REQ-003 exception_submit in 1; ecode_submit in 6; esubcode_submit in 9; exception_pc_submit in 32; exception_maddr_submit in 32; ertn_submit in 1. All are from the writeback stage and are valid when exception_submit or ertn_submit is high.
REQ-004 csr_num in 14, selects the CSR for read and write.
REQ-005 csr_we in 1; csr_wmask in 32; csr_wvalue in 32.
REQ-006 csr_rvalue out 32, combinational read data for csr_num.
REQ-007 ex_entry out 32, equal to EENTRY; ertn_entry out 32, equal to ERA.
REQ-008 has_int out 1, pending enabled interrupt.
REQ-009 counter_value out 64, free-running stable counter.

Function
REQ-010 The block SHALL implement these CSRs at these addresses: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44. An unimplemented csr_num SHALL read 0 and ignore writes.
REQ-011 CRMD fields SHALL be PLV[1:0], IE[2] and DA[3]; other bits read 0.
REQ-012 PRMD fields SHALL be PPLV[1:0] and PIE[2].
REQ-013 ECFG field SHALL be LIE at bits 9:0 and 12:11.
REQ-014 ESTAT fields SHALL be IS[1:0] (software-writable), IS[11] (timer, read-only to csr_we), Ecode[21:16] and EsubCode[30:22].
REQ-015 EENTRY SHALL implement bits 31:6; bits 5:0 read 0.
REQ-016 TCFG fields SHALL be En[0], Periodic[1] and InitVal[31:2].
REQ-017 TVAL SHALL be read-only.
REQ-018 TICLR SHALL read 0.
REQ-019 A CSR write SHALL occur when csr_we=1 and neither submit input is high, and SHALL update each writable bit as new = (old & ~csr_wmask) | (csr_wvalue & csr_wmask).
REQ-020 A CSR write SHALL become visible on csr_rvalue the next cycle; csr_rvalue is not write-through.
REQ-021 When exception_submit=1, on the next edge: PRMD.PPLV<=CRMD.PLV; PRMD.PIE<=CRMD.IE; CRMD.PLV<=0; CRMD.IE<=0; ERA<=exception_pc_submit; ESTAT.Ecode<=ecode_submit; ESTAT.EsubCode<=esubcode_submit.
REQ-022 On an exception with ecode 0x08 (ADEF), BADV SHALL be loaded with exception_pc_submit; with ecode 0x09 (ALE), BADV SHALL be loaded with exception_maddr_submit; otherwise BADV is unchanged.
REQ-023 When ertn_submit=1 and exception_submit=0, on the next edge: CRMD.PLV<=PRMD.PPLV; CRMD.IE<=PRMD.PIE; PRMD is unchanged.
REQ-024 If exception_submit and ertn_submit are both high, the exception SHALL be taken and the ertn ignored.
REQ-025 When either submit input is high, a same-cycle csr_we SHALL be dropped, with no partial update.
REQ-026 A TCFG write SHALL load TVAL with {new InitVal, 2'b00} in the same edge.
REQ-027 Timer decrement: when En=1 and TVAL!=0 and there is no TCFG write, TVAL SHALL decrement by 1 each cycle.
REQ-028 Timer expiry: when En=1 and TVAL==1, on the next edge ESTAT.IS[11]<=1, and TVAL SHALL become {InitVal,2'b00} if Periodic=1, else 0.
REQ-029 When TVAL==0 the timer SHALL hold and raise no further interrupt; a periodic reload of 0 stops the timer.
REQ-030 When En=0, TVAL SHALL hold its value.
REQ-031 A TICLR write whose masked bit0 is 1 SHALL clear IS[11].
REQ-032 If a TICLR clear and a timer expiry occur in the same edge, the expiry SHALL win and IS[11]=1.
REQ-033 has_int SHALL equal CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinationally.
REQ-034 counter_value SHALL increment by 1 every cycle and wrap from 2^64-1 to 0.
REQ-035 TID SHALL be a fully writable 32-bit register.

Reset
REQ-036 On rst=1 at a rising edge: CRMD=0x00000008 (DA=1, PLV=0, IE=0); PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0-3, TID, TCFG, TVAL = 0; counter_value=0.
REQ-037 Reset SHALL override any same-cycle submit or write.
REQ-038 Reset asserted mid-countdown SHALL stop the timer and clear IS[11].
REQ-039 Outputs SHALL reflect reset values the cycle after the reset edge.

Verification
REQ-040 The bench SHALL cover: reset, then read CRMD -> 0x8; read ESTAT -> 0; has_int=0; counter_value increments 0,1,2.
REQ-041 The bench SHALL cover: CRMD.PLV=3 and IE=1; exception_submit with ecode 0x09, pc 0x1c000100, maddr 0x00000203 -> next cycle CRMD=0x8, PRMD=0x7, ERA=0x1c000100, BADV=0x00000203, ESTAT[21:16]=0x09.
REQ-042 The bench SHALL cover: after the previous scenario, ertn_submit -> CRMD.PLV=3, IE=1; ertn_entry=0x1c000100.
REQ-043 The bench SHALL cover: write TCFG=0x0000000B (En=1, Periodic=1, InitVal=2) -> TVAL=8, then 7..1; IS[11]=1 the cycle after TVAL=1, and TVAL reloads 8; with ECFG.LIE[11]=1 and IE=1, has_int=1; TICLR write 0x1 -> IS[11]=0.
REQ-044 The bench SHALL cover: simultaneous exception_submit, ertn_submit and csr_we to SAVE0 -> exception taken; SAVE0 unchanged; PLV/IE restore not performed.
REQ-045 The bench SHALL cover: csr_we to ESTAT with wmask 0xFFFFFFFF and wvalue 0xFFFFFFFF -> only IS[1:0] set; IS[11], Ecode and EsubCode are unchanged.
